// File: rtl/rt_word_collector.sv
// Reassembles MSB-first 32-bit r/t word streams into full-width operands and latches n0prime at start.
// Optional XFER_TIMEOUT_EN macro adds an inter-word gap watchdog that aborts a stalled capture.
module rt_word_collector #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_LENGTH    = 1024,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int WORDS         = DATA_LENGTH / DATA_WIDTH,
  localparam int CNT_W         = $clog2(WORDS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_transfer,
  input  logic                   word_valid,
  input  logic [DATA_WIDTH-1:0]  r_word,
  input  logic [DATA_WIDTH-1:0]  t_word,
  input  logic [DATA_WIDTH-1:0]  n0p_in,
  output logic [DATA_LENGTH-1:0] r_out,
  output logic [DATA_LENGTH-1:0] t_out,
  output logic [DATA_WIDTH-1:0]  n0p_out,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   timeout
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] r_q, r_d, t_q, t_d;
  logic [DATA_WIDTH-1:0]  n0p_q, n0p_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   start_prev_q, start_prev_d;
  logic                   start_rise;

`ifdef XFER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             timeout_q, timeout_d;
`endif

  assign start_rise = start_transfer & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    t_d          = t_q;
    n0p_d        = n0p_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    start_prev_d = start_transfer;
`ifdef XFER_TIMEOUT_EN
    gap_d        = gap_q;
    timeout_d    = timeout_q;
`endif
    // A rising start wins in every state; any word in that cycle is dropped.
    if (start_rise) begin
      n0p_d     = n0p_in;
      cnt_d     = '0;
      overrun_d = 1'b0;
      busy_d    = 1'b1;
      state_d   = COLLECT;
`ifdef XFER_TIMEOUT_EN
      gap_d     = '0;
      timeout_d = 1'b0;
`endif
    end else if (state_q == COLLECT) begin
      if (word_valid) begin
        r_d = {r_q[DATA_LENGTH-DATA_WIDTH-1:0], r_word};
        t_d = {t_q[DATA_LENGTH-DATA_WIDTH-1:0], t_word};
`ifdef XFER_TIMEOUT_EN
        gap_d = '0;
`endif
        if (cnt_q == CNT_W'(WORDS - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef XFER_TIMEOUT_EN
      else begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_d == GAP_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
`endif
    end else if (word_valid) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      r_q          <= '0;
      t_q          <= '0;
      n0p_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef XFER_TIMEOUT_EN
      gap_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      t_q          <= t_d;
      n0p_q        <= n0p_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      start_prev_q <= start_prev_d;
`ifdef XFER_TIMEOUT_EN
      gap_q        <= gap_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign r_out   = r_q;
  assign t_out   = t_q;
  assign n0p_out = n0p_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
`ifdef XFER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // Watchdog absent: constant 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_rt_word_collector.sv
// Bench for rt_word_collector: per-cycle comparison against a behavioural model, directed scenarios, random traffic.
// Build with XFER_TIMEOUT_EN defined to cover the watchdog.
module tb_rt_word_collector;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n, start_transfer, word_valid;
  logic [31:0]   r_word, t_word, n0p_in;
  logic [1023:0] r_out, t_out;
  logic [31:0]   n0p_out;
  logic          busy, done, overrun, timeout;

  always #5 clk = ~clk;

  rt_word_collector dut (
    .clk(clk), .rst_n(rst_n), .start_transfer(start_transfer), .word_valid(word_valid),
    .r_word(r_word), .t_word(t_word), .n0p_in(n0p_in),
    .r_out(r_out), .t_out(t_out), .n0p_out(n0p_out),
    .busy(busy), .done(done), .overrun(overrun), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      int idx = 0;
      errors++;
      for (int w = 31; w >= 0; w--) if (act[w*32 +: 32] !== exp[w*32 +: 32]) idx = w;
      $display("FAIL %s word %0d got %h want %h", name, idx, act[idx*32 +: 32], exp[idx*32 +: 32]);
    end
  endtask

  // Behavioural model: operands are the stream of words appended at the low end.
  logic [1023:0] m_r, m_t;
  logic [31:0]   m_n0p;
  bit            m_busy, m_done, m_ov, m_to, m_prev, m_collecting;
  int            m_cnt, m_gap;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_r = '0; m_t = '0; m_n0p = '0;
      m_busy = 0; m_done = 0; m_ov = 0; m_to = 0; m_prev = 0;
      m_collecting = 0; m_cnt = 0; m_gap = 0;
    end else begin
      bit rise;
      rise   = start_transfer && !m_prev;
      m_prev = start_transfer;
      m_done = 0;
      if (rise) begin
        m_n0p = n0p_in; m_cnt = 0; m_ov = 0; m_to = 0; m_busy = 1;
        m_collecting = 1; m_gap = 0;
      end else if (m_collecting) begin
        if (word_valid) begin
          m_r = (m_r << 32) | 1024'(r_word);
          m_t = (m_t << 32) | 1024'(t_word);
          m_cnt++;
          m_gap = 0;
          if (m_cnt == 32) begin
            m_cnt = 0; m_done = 1; m_busy = 0; m_collecting = 0;
          end
        end else begin
`ifdef XFER_TIMEOUT_EN
          m_gap++;
          if (m_gap == TMO) begin
            m_to = 1; m_busy = 0; m_collecting = 0;
          end
`endif
        end
      end else if (word_valid) begin
        m_ov = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk_wide("r_out", r_out, m_r);
      chk_wide("t_out", t_out, m_t);
      chk("n0p_out", n0p_out, m_n0p);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("timeout", 32'(timeout), 32'(m_to));
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic step(input bit st, input bit wv, input logic [31:0] rw, input logic [31:0] tw);
    @(negedge clk);
    start_transfer = st; word_valid = wv; r_word = rw; t_word = tw;
  endtask

  task automatic stream(input int n, input logic [31:0] rb, input logic [31:0] tb_base, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1, 1, rb + 32'(i), tb_base + 32'(i));
      repeat (gap) step(1, 0, 32'h0, 32'h0);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  int d0;

  initial begin
    rst_n = 0; start_transfer = 0; word_valid = 0; r_word = 0; t_word = 0; n0p_in = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    settle();
    chk_wide("rst_r", r_out, 1024'h0);
    chk("rst_n0p", n0p_out, 32'h0);
    chk("rst_flags", {28'h0, busy, done, overrun, timeout}, 32'h0);
    @(negedge clk); rst_n = 1;

    // Scenario 1: back-to-back 32 words.
    n0p_in = 32'hDEADBEEF;
    step(1, 0, 0, 0);
    d0 = done_seen;
    stream(32, 32'h1, 32'h100, 0);
    settle();
    chk("s1_done_lat", 32'(done), 32'h1);
    chk("s1_r_top", r_out[1023:992], 32'h1);
    chk("s1_r_low", r_out[31:0], 32'd32);
    chk("s1_t_top", t_out[1023:992], 32'h100);
    chk("s1_n0p", n0p_out, 32'hDEADBEEF);
    chk("s1_overrun", 32'(overrun), 32'h0);
    chk("s1_model_r_top", m_r[1023:992], 32'h1);
    chk("s1_model_t_low", m_t[31:0], 32'h11F);
    step(1, 0, 0, 0);
    settle();
    chk("s1_done_once", 32'(done_seen - d0), 32'h1);

    // Scenario 2: trailing 33rd word flags overrun.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    stream(32, 32'h1, 32'h100, 0);
    step(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step(1, 0, 0, 0);
    settle();
    chk("s2_overrun", 32'(overrun), 32'h1);
    chk("s2_r_low", r_out[31:0], 32'd32);

    // Scenario 3: 3-cycle gaps.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    d0 = done_seen;
    stream(32, 32'h1, 32'h100, 3);
    settle();
    chk("s3_done_cnt", 32'(done_seen - d0), 32'h1);
    chk("s3_r_top", r_out[1023:992], 32'h1);
    chk("s3_r_low", r_out[31:0], 32'd32);
    chk("s3_t_top", t_out[1023:992], 32'h100);

    // Scenario 4: held-high start does not re-trigger.
    d0 = done_seen;
    stream(32, 32'h500, 32'h600, 0);
    step(1, 0, 0, 0);
    settle();
    chk("s4_no_retrig_done", 32'(done_seen - d0), 32'h0);
    chk("s4_no_retrig_r", r_out[31:0], 32'd32);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    stream(32, 32'h500, 32'h600, 0);
    step(1, 0, 0, 0);
    settle();
    chk("s4_second_done", 32'(done_seen - d0), 32'h1);
    chk("s4_second_r_top", r_out[1023:992], 32'h500);

    // Scenario 5: restart after 10 words.
    step(0, 0, 0, 0);
    n0p_in = 32'hA5A5A5A5;
    step(1, 0, 0, 0);
    stream(10, 32'h900, 32'h900, 0);
    step(0, 0, 0, 0);
    n0p_in = 32'h5A5A5A5A;
    step(1, 0, 0, 0);
    stream(32, 32'h700, 32'h800, 0);
    step(1, 0, 0, 0);
    settle();
    chk("s5_r_top", r_out[1023:992], 32'h700);
    chk("s5_r_low", r_out[31:0], 32'h71F);
    chk("s5_t_top", t_out[1023:992], 32'h800);
    chk("s5_n0p", n0p_out, 32'h5A5A5A5A);

    // Scenario 6: reset mid-capture.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    d0 = done_seen;
    stream(16, 32'h1, 32'h100, 0);
    @(negedge clk); rst_n = 0; word_valid = 0;
    settle();
    chk_wide("s6_r_zero", r_out, 1024'h0);
    chk_wide("s6_t_zero", t_out, 1024'h0);
    chk("s6_n0p", n0p_out, 32'h0);
    chk("s6_flags", {28'h0, busy, done, overrun, timeout}, 32'h0);
    @(negedge clk); rst_n = 1; start_transfer = 0;
    chk("s6_no_done", 32'(done_seen - d0), 32'h0);

`ifdef XFER_TIMEOUT_EN
    step(1, 0, 0, 0);
    d0 = done_seen;
    stream(5, 32'h1, 32'h100, 0);
    repeat (TMO + 6) step(1, 0, 0, 0);
    settle();
    chk("tmo_timeout", 32'(timeout), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_no_done", 32'(done_seen - d0), 32'h0);
    chk("tmo_partial_r", r_out[31:0], 32'h5);
    step(0, 0, 0, 0);
`endif

    // Random traffic, checked every cycle by the model.
    begin
      bit st = 0;
      int stall = 0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        rst_n = ($urandom_range(0, 799) != 0);
        if ($urandom_range(0, 39) == 0) st = ~st;
        if (stall > 0) begin
          stall--;
          word_valid = 0;
        end else begin
          if ($urandom_range(0, 59) == 0) stall = $urandom_range(0, 80);
          word_valid = ($urandom_range(0, 9) < 7);
        end
        start_transfer = st;
        r_word = $urandom; t_word = $urandom; n0p_in = $urandom;
      end
    end
    step(0, 0, 0, 0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rt_word_collector.md
Name: rt_word_collector

Overview:
- Receiving end of the secondary-input word stream.
- Captures the 32-bit r and t words, streamed MSB word first after the start-transfer flag rises, and reassembles them into full 1024-bit r and t operands.
- Latches n0prime at the same start event.
- Sits between the secondary-input generator and the Montgomery exponentiation core; the core reads the operands when done pulses.

Parameters:
- DATA_WIDTH, 32, width of each streamed word and of n0prime.
- DATA_LENGTH, 1024, width of the reassembled r and t operands.
- WORDS, DATA_LENGTH/DATA_WIDTH (32), words per operand. Derived; not overridden.
- TIMEOUT_CYCLES, 64, cycles allowed between consecutive words. Used only with XFER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start_transfer  in  1  level flag from the generator. Its rising edge begins a capture.
- word_valid  in  1  r_word and t_word carry a new word this cycle.
- r_word  in  DATA_WIDTH  next r word, MSB word first.
- t_word  in  DATA_WIDTH  next t word, MSB word first.
- n0p_in  in  DATA_WIDTH  n0prime from the generator, stable when start_transfer rises.
- r_out  out  DATA_LENGTH  reassembled r.
- t_out  out  DATA_LENGTH  reassembled t.
- n0p_out  out  DATA_WIDTH  latched n0prime.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse: r_out, t_out and n0p_out are complete.
- overrun  out  1  sticky: a word arrived while not collecting.
- timeout  out  1  sticky, only with XFER_TIMEOUT_EN. Otherwise tied 0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - r_out, t_out, n0p_out = 0.
  - busy, done, overrun, timeout = 0.
  - state = IDLE, word count = 0, start_prev = 0.
  - Reset mid-capture discards partial data.
- Start detection:
  - start_prev registers start_transfer.
  - start_rise = start_transfer & ~start_prev.
  - A level held high does not re-trigger.
- FSM: IDLE, COLLECT, HOLD.
- IDLE:
  - On start_rise: n0p_out <= n0p_in, count <= 0, overrun <= 0, timeout <= 0, busy <= 1, go to COLLECT.
  - A word_valid in the start_rise cycle is ignored. The first word is expected no earlier than the next cycle.
- COLLECT, on each word_valid:
  - r_out <= {r_out[DATA_LENGTH-DATA_WIDTH-1:0], r_word}; t_out shifts the same way with t_word.
  - count <= count+1.
  - After WORDS words the first word received sits in r_out[1023:992].
  - Cycles without word_valid hold all state (gaps allowed).
- COLLECT completion:
  - On the cycle the WORDS-th word is captured, count wraps to 0.
  - Next posedge: done=1 for exactly one cycle, busy=0, go to HOLD.
  - Latency is one cycle from last word to done.
- COLLECT restart: start_rise during COLLECT restarts capture (count <= 0, n0p_out re-latched) and stays in COLLECT. A simultaneous word_valid is ignored.
- HOLD:
  - Outputs are held stable.
  - word_valid in IDLE or HOLD sets overrun and does not alter r_out/t_out. This covers the generator's extra trailing word.
  - start_rise behaves as in IDLE.
- done and start_rise in the same cycle: done still pulses and the new capture begins.
- Count width is clog2(WORDS)+1 bits. There is no arithmetic beyond increment and compare.

Optional Feature:
- Macro XFER_TIMEOUT_EN.
- Defined:
  - An idle-gap counter resets on every word_valid and on start_rise, and increments in COLLECT otherwise.
  - When it reaches TIMEOUT_CYCLES: timeout <= 1 (sticky), busy <= 0, go to IDLE, no done.
  - r_out/t_out keep their partial contents.
- Undefined: no counter; timeout is constant 0; COLLECT waits indefinitely.

Test Plan:
- Reset, then start_transfer rises with n0p_in=0xDEADBEEF. Next 32 cycles word_valid=1, r_word=i+1, t_word=0x100+i (i=0..31). Required:
  - done pulses one cycle after word 32.
  - r_out[1023:992]=1 and r_out[31:0]=32.
  - t_out[1023:992]=0x100.
  - n0p_out=0xDEADBEEF.
  - overrun=0.
- Same stream plus a 33rd word 0xFFFFFFFF. Required: overrun=1 and r_out[31:0] still 32.
- Words with 3-cycle gaps between each: same final values as the first scenario; done after the 32nd word only.
- start_transfer held high across two captures: the second capture requires start_transfer to go low then high again.
- start_transfer drops after 10 words then rises again, followed by 32 words: result contains only the new 32 words, with n0p re-latched.
- rst_n=0 after 16 words: all outputs 0, no done. With XFER_TIMEOUT_EN, stalling after 5 words for 64 cycles sets timeout=1, busy=0, and done never asserts.
